lut7_cfg_writer: RTL and testbench

- Run-time programmable 7-input LUT for iCE40 designs: the write side of a truth-table function.
- A 128-bit truth table is streamed in as 32 nibbles over a valid/ready handshake into a shadow table, then committed atomically to the active table.
- Evaluation of the active table is registered, one-cycle latency.
- Sits beside fabric logic that needs a reconfigurable function without re-synthesis; the host or config controller drives the cfg side.

---
 rtl/lut7_cfg_writer.sv | 116 +++++++++++
 tb/tb_lut7_cfg_writer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lut7_cfg_writer.sv
// Run-time programmable 7-input LUT: streams a 128-bit truth table in as nibbles and commits it atomically.
// Optional parity checking on cfg_data is enabled with `define LUT7_CFG_PARITY_EN.
module lut7_cfg_writer #(
    parameter logic [127:0] INIT    = 128'h0,
    parameter int           NIBBLES = 32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cfg_start,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_data,
`ifdef LUT7_CFG_PARITY_EN
    input  logic       cfg_par,
`endif
    output logic       cfg_ready,
    output logic       cfg_done,
    output logic       cfg_err,
    input  logic [6:0] I,
    output logic       O,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    localparam logic [4:0] LAST_NIBBLE = 5'(NIBBLES - 1);

    state_t       state;
    logic [4:0]   cnt;
    logic [127:0] shadow;
    logic [127:0] active;
    logic         start_pending;
    logic         par_ok;

`ifdef LUT7_CFG_PARITY_EN
    assign par_ok = (cfg_par == ^cfg_data);
`else
    assign par_ok = 1'b1;
`endif

    // A start seen during COMMIT is remembered so the commit itself is never skipped.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            cnt           <= '0;
            shadow        <= '0;
            active        <= INIT;
            start_pending <= 1'b0;
            cfg_ready     <= 1'b0;
            cfg_done      <= 1'b0;
            cfg_err       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start || start_pending) begin
                        state         <= LOAD;
                        cnt           <= '0;
                        cfg_err       <= 1'b0;
                        cfg_ready     <= 1'b1;
                        busy          <= 1'b1;
                        start_pending <= 1'b0;
                    end else if (cfg_valid) begin
                        cfg_err <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        cnt     <= '0;
                        cfg_err <= 1'b0;
                    end else if (cfg_valid && cfg_ready) begin
                        if (!par_ok) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            cfg_err   <= 1'b1;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            shadow[{cnt, 2'b00} +: 4] <= cfg_data;
                            if (cnt == LAST_NIBBLE) begin
                                state     <= COMMIT;
                                cnt       <= '0;
                                cfg_ready <= 1'b0;
                                cfg_done  <= 1'b1;
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
                end
                COMMIT: begin
                    active <= shadow;
                    state  <= IDLE;
                    busy   <= 1'b0;
                    if (cfg_start) begin
                        start_pending <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            O <= INIT[0];
        end else begin
            O <= active[I];
        end
    end

endmodule

// File: tb/tb_lut7_cfg_writer.sv
// Directed self-checking bench for lut7_cfg_writer; parity steps run only when LUT7_CFG_PARITY_EN is defined.
module tb_lut7_cfg_writer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_data = 4'h0;
    logic       cfg_par = 1'b0;
    logic       cfg_ready;
    logic       cfg_done;
    logic       cfg_err;
    logic [6:0] I = 7'd0;
    logic       O;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [127:0] tbl_a    = {32{4'hA}};
    logic [127:0] tbl_mix  = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    logic [127:0] tbl_5    = {32{4'h5}};
    logic [127:0] tbl_f    = {32{4'hF}};
    logic [127:0] tbl_3    = {32{4'h3}};
    int           mix_idx[7] = '{0, 4, 17, 63, 64, 100, 127};

    lut7_cfg_writer dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
`ifdef LUT7_CFG_PARITY_EN
        .cfg_par   (cfg_par),
`endif
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .I         (I),
        .O         (O),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic start_pulse();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_nibble(input logic [3:0] d, input bit bad_par);
        cfg_data  = d;
        cfg_par   = bad_par ? ~(^d) : ^d;
        cfg_valid = 1'b1;
        for (int k = 0; k < 16 && !cfg_ready; k++) tick();
        if (!cfg_ready) begin
            tests_run++;
            tests_failed++;
            $error("[TB] FAIL ready_timeout: observed cfg_ready=%0b expected 1", cfg_ready);
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic load_nibbles(input logic [127:0] tbl, input int first, input int count, input bit stall);
        for (int i = first; i < first + count; i++) begin
            if (stall) tick();
            send_nibble(tbl[4*i +: 4], 1'b0);
        end
    endtask

    task automatic lookup(input int idx, input logic expected, input string tag);
        I = 7'(idx);
        tick();
        check(tag, O, expected);
    endtask

    initial begin
        // reset state
        RESET = 1'b1;
        repeat (3) tick();
        check("reset_O", O, 0);
        check("reset_ready", cfg_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", cfg_done, 0);
        check("reset_err", cfg_err, 0);
        RESET = 1'b0;
        tick();
        lookup(5, 1'b0, "init_O_i5");
        lookup(127, 1'b0, "init_O_i127");

        // back-to-back load of all-A
        start_pulse();
        check("a_ready", cfg_ready, 1);
        check("a_busy", busy, 1);
        load_nibbles(tbl_a, 0, 31, 1'b0);
        check("a_no_done_31", cfg_done, 0);
        load_nibbles(tbl_a, 31, 1, 1'b0);
        check("a_done", cfg_done, 1);
        check("a_commit_ready", cfg_ready, 0);
        check("a_commit_busy", busy, 1);
        I = 7'd1;
        tick();
        check("a_old_on_commit", O, 0);
        check("a_done_cleared", cfg_done, 0);
        check("a_idle_busy", busy, 0);
        tick();
        check("a_new_i1", O, 1);
        lookup(0, 1'b0, "a_i0");
        lookup(127, 1'b1, "a_i127");

        // stalled load of a mixed pattern
        start_pulse();
        load_nibbles(tbl_mix, 0, 31, 1'b1);
        check("mix_no_done_31", cfg_done, 0);
        check("mix_busy", busy, 1);
        load_nibbles(tbl_mix, 31, 1, 1'b1);
        check("mix_done", cfg_done, 1);
        tick();
        for (int j = 0; j < 7; j++) begin
            lookup(mix_idx[j], tbl_mix[mix_idx[j]], $sformatf("mix_i%0d", mix_idx[j]));
        end

        // partial load, restart with a same-cycle nibble that must be dropped, then all-5
        start_pulse();
        load_nibbles(tbl_f, 0, 20, 1'b0);
        lookup(4, tbl_mix[4], "partial_keeps_active");
        check("partial_no_done", cfg_done, 0);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 4'hF;
        cfg_par   = ^cfg_data;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        load_nibbles(tbl_5, 0, 31, 1'b0);
        check("five_no_done_31", cfg_done, 0);
        load_nibbles(tbl_5, 31, 1, 1'b0);
        check("five_done", cfg_done, 1);
        tick();
        lookup(0, 1'b1, "five_i0");
        lookup(1, 1'b0, "five_i1");
        lookup(80, 1'b1, "five_i80");
        lookup(81, 1'b0, "five_i81");
        lookup(127, 1'b0, "five_i127");

        // cfg_valid while idle
        cfg_valid = 1'b1;
        cfg_data  = 4'hF;
        tick();
        cfg_valid = 1'b0;
        check("idle_valid_err", cfg_err, 1);
        check("idle_valid_busy", busy, 0);
        lookup(0, 1'b1, "idle_valid_table_i0");
        lookup(1, 1'b0, "idle_valid_table_i1");
        start_pulse();
        check("start_clears_err", cfg_err, 0);
        check("start_busy", busy, 1);

`ifdef LUT7_CFG_PARITY_EN
        // bad parity on nibble 10 aborts the load
        load_nibbles(tbl_3, 0, 10, 1'b0);
        send_nibble(4'h3, 1'b1);
        check("par_err", cfg_err, 1);
        check("par_busy", busy, 0);
        check("par_ready", cfg_ready, 0);
        check("par_no_done", cfg_done, 0);
        tick();
        check("par_no_done_late", cfg_done, 0);
        lookup(0, 1'b1, "par_old_i0");
        lookup(1, 1'b0, "par_old_i1");
        start_pulse();
        check("par_restart_err", cfg_err, 0);
`endif

        // reset in the middle of a load
        load_nibbles(tbl_f, 0, 10, 1'b0);
        I = 7'd0;
        RESET = 1'b1;
        #1;
        check("midreset_O", O, 0);
        check("midreset_busy", busy, 0);
        check("midreset_ready", cfg_ready, 0);
        tick();
        RESET = 1'b0;
        tick();
        lookup(0, 1'b0, "post_reset_i0");
        lookup(2, 1'b0, "post_reset_i2");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
